// File: rtl/mt_bht_pkg.sv
// Shared types for the thread-aware branch history table (mt_bht).
// Holds the core configuration record, the branch-resolution record,
// the BHT row / pending-update records, the sweep FSM state type and
// the 2-bit saturating counter helper.
package mt_bht_pkg;

    // Core configuration: only the fields the BHT needs.
    typedef struct packed {
        logic [31:0] VLEN;
        logic        RVC;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32, RVC: 1'b1};

    // Widths of the default resolution record.
    localparam int unsigned RES_VLEN      = 32;
    localparam int unsigned RES_TID_W     = 4;
    // Widest row index a pending update can carry.
    localparam int unsigned BHT_IDX_W_MAX = 16;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        logic                 valid;
        logic [RES_VLEN-1:0]  pc;
        logic                 is_taken;
        cf_t                  cf_type;
        logic [RES_TID_W-1:0] thread_id;
    } bp_resolve_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } bht_row_t;

    typedef struct packed {
        logic                     valid;
        logic [BHT_IDX_W_MAX-1:0] index;
        logic                     taken;
    } bht_upd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] bht_sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11) begin
            nxt = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mt_bht_sweep.sv
// Flush sweep controller for mt_bht: IDLE/SWEEP FSM plus the row counter
// that clears one BHT row per cycle. A flush in either state (re)starts
// the sweep at row 0. The FSM state is exported on state_o.
module mt_bht_sweep
    import mt_bht_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    localparam int unsigned IDX_W     = $clog2(NR_ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               clr_en_o,
    output logic [IDX_W-1:0]   clr_idx_o,
    output sweep_state_t       state_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

    sweep_state_t     state_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;

    // Sweep FSM: state, row counter and registered busy flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (flush_i) begin
                        idx_q <= '0;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign clr_en_o  = (state_q == SWEEP);
    assign clr_idx_o = idx_q;
    assign state_o   = state_q;

endmodule

// File: rtl/mt_bht.sv
// Thread-aware branch history table. Trains 2-bit saturating direction
// counters from execute-stage resolutions and answers one combinational
// direction lookup per cycle. A flush clears the table one row per cycle.
// Build option: MT_BHT_THREAD_PARTITION_EN gives each thread its own slice
// of rows; without it all threads share rows and alias by PC.
//
// Interface semantics: both the resolution and the lookup are valid-only
// (no ready). A resolution is consumed in the cycle its valid is high, or
// silently dropped when it is not a conditional branch, a sweep is running,
// or flush_i is high. A lookup is answered in the same cycle it is
// presented.
module mt_bht
    import mt_bht_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg      = cva6_cfg_empty,
    parameter type         bp_resolve_t = mt_bht_pkg::bp_resolve_t,
    parameter int unsigned NR_ENTRIES   = 1024,
    parameter int unsigned NR_THREADS   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          lookup_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]       lookup_pc_i,
    input  logic [$clog2(NR_THREADS)-1:0] lookup_thread_i,
    input  bp_resolve_t                   resolved_branch_i,
    output logic                          prediction_valid_o,
    output logic                          prediction_taken_o,
    output logic                          busy_o
);

    localparam int unsigned OFFSET   = CVA6Cfg.RVC ? 1 : 2;
    localparam int unsigned IDX_W    = $clog2(NR_ENTRIES);
    localparam int unsigned TID_W    = $clog2(NR_THREADS);
    localparam int unsigned ROW_BITS = $clog2(NR_ENTRIES / NR_THREADS);

    bht_row_t         bht_q [NR_ENTRIES];
    bht_upd_t         upd_q;
    sweep_state_t     sweep_state;
    logic             clr_en;
    logic [IDX_W-1:0] clr_idx;
    logic             idle;
    logic [IDX_W-1:0] res_idx;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_qualify;
    logic             upd_we;
    bht_row_t         upd_old;
    bht_row_t         upd_row;
    bht_row_t         lk_row;
    logic             unused_bits;

    mt_bht_sweep #(
        .NR_ENTRIES(NR_ENTRIES)
    ) i_sweep (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .clr_en_o (clr_en),
        .clr_idx_o(clr_idx),
        .state_o  (sweep_state)
    );

    assign idle = (sweep_state == IDLE);

`ifdef MT_BHT_THREAD_PARTITION_EN
    assign res_idx = {resolved_branch_i.thread_id[TID_W-1:0],
                      resolved_branch_i.pc[OFFSET+ROW_BITS-1:OFFSET]};
    assign lk_idx  = {lookup_thread_i, lookup_pc_i[OFFSET+ROW_BITS-1:OFFSET]};
`else
    assign res_idx = resolved_branch_i.pc[OFFSET+IDX_W-1:OFFSET];
    assign lk_idx  = lookup_pc_i[OFFSET+IDX_W-1:OFFSET];
`endif

    // Only part of the PCs, thread ids and the update index select a row.
    assign unused_bits = ^{lookup_pc_i, lookup_thread_i, resolved_branch_i, upd_q.index};

    assign upd_qualify = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch)
                         && idle && !flush_i;
    assign upd_idx     = upd_q.index[IDX_W-1:0];
    // A flush discards the pending update instead of writing it.
    assign upd_we      = upd_q.valid && idle && !flush_i;

    // Post-update row value for the pending update; shared by write and bypass.
    always_comb begin
        upd_old       = bht_q[upd_idx];
        upd_row.valid = 1'b1;
        if (upd_old.valid) begin
            upd_row.cnt = bht_sat_update(upd_old.cnt, upd_q.taken);
        end else begin
            upd_row.cnt = upd_q.taken ? 2'b10 : 2'b01;
        end
    end

    // One-entry update register: captures a qualifying resolution.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            upd_q <= '0;
        end else if (flush_i) begin
            upd_q <= '0;
        end else begin
            upd_q.valid <= upd_qualify;
            upd_q.index <= BHT_IDX_W_MAX'(res_idx);
            upd_q.taken <= resolved_branch_i.is_taken;
        end
    end

    // Counter array: reset clear, sweep clear, then pending update write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                bht_q[i] <= '0;
            end
        end else if (clr_en) begin
            bht_q[clr_idx] <= '0;
        end else if (upd_we) begin
            bht_q[upd_idx] <= upd_row;
        end
    end

    // Lookup row with bypass of a pending update to the same index.
    always_comb begin
        lk_row = bht_q[lk_idx];
        if (upd_q.valid && (upd_idx == lk_idx)) begin
            lk_row = upd_row;
        end
    end

    assign prediction_valid_o = lookup_valid_i && lk_row.valid && idle;
    assign prediction_taken_o = prediction_valid_o && lk_row.cnt[1];

endmodule
